// File: rtl/nios_system_sysinfo.sv
// rtl/nios_system_sysinfo.sv - system info slave: build ID, timestamp, uptime counter, scratch, control
module nios_system_sysinfo #(
    parameter logic [31:0] SYSID       = 32'h00000001,
    parameter logic [31:0] TIMESTAMP   = 32'd1409232964,
    parameter int          CNT_W       = 64,
    parameter logic [31:0] SCRATCH_RST = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int HI_W = CNT_W - 32;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_UP_LO   = 3'd2;
    localparam logic [2:0] A_UP_HI   = 3'd3;
    localparam logic [2:0] A_SCRATCH = 3'd4;
    localparam logic [2:0] A_CTRL    = 3'd5;

    logic rd_acc;
    logic wr_acc;
    assign rd_acc = chipselect & read;
    assign wr_acc = chipselect & write;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HI_W-1:0]  hi_snap_q, hi_snap_d;
    logic [31:0]      scratch_q, scratch_d;
    logic             en_q, en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             rdv_q, rdv_d;
    logic             clr_pulse;
    logic [31:0]      hi_ext;

    // Zero-extend the latched upper counter bits to a full word
    always_comb begin
        hi_ext = '0;
        hi_ext[HI_W-1:0] = hi_snap_q;
    end

    // Read mux: samples current register values; data is held when no read is accepted
    always_comb begin
        readdata_d = readdata_q;
        rdv_d      = rd_acc;
        if (rd_acc) begin
            case (address)
                A_ID:      readdata_d = SYSID;
                A_TSTAMP:  readdata_d = TIMESTAMP;
                A_UP_LO:   readdata_d = cnt_q[31:0];
                A_UP_HI:   readdata_d = hi_ext;
                A_SCRATCH: readdata_d = scratch_q;
                A_CTRL:    readdata_d = {31'd0, en_q};
                default:   readdata_d = 32'd0;
            endcase
        end
    end

    // Register writes, counter update and snapshot of the upper counter half
    always_comb begin
        scratch_d = scratch_q;
        en_d      = en_q;
        clr_pulse = 1'b0;
        hi_snap_d = hi_snap_q;
        cnt_d     = cnt_q;
        if (en_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (wr_acc) begin
            case (address)
                A_UP_LO: begin
                    // direct load only while the counter is stopped
                    if (!en_q) cnt_d[31:0] = writedata;
                end
                A_UP_HI: begin
                    if (!en_q) cnt_d[CNT_W-1:32] = writedata[HI_W-1:0];
                end
                A_SCRATCH: scratch_d = writedata;
                A_CTRL: begin
                    en_d      = writedata[0];
                    clr_pulse = writedata[1];
                end
                default: ;
            endcase
        end
        if (clr_pulse) begin
            cnt_d     = '0;
            hi_snap_d = '0;
        end
        // a LO read captures the pre-update upper half so the HI read pairs with it
        if (rd_acc && (address == A_UP_LO)) begin
            hi_snap_d = cnt_q[CNT_W-1:32];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            hi_snap_q  <= '0;
            scratch_q  <= SCRATCH_RST;
            en_q       <= 1'b1;
            readdata_q <= 32'd0;
            rdv_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hi_snap_q  <= hi_snap_d;
            scratch_q  <= scratch_d;
            en_q       <= en_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_nios_system_sysinfo.sv
// tb/tb_nios_system_sysinfo.sv - self-checking bench for nios_system_sysinfo
module tb_nios_system_sysinfo;

    logic        clock;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [31:0] readdata33;
    logic        readdatavalid33;

    int errors = 0;
    int checks = 0;

    nios_system_sysinfo dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .chipselect    (chipselect),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    nios_system_sysinfo #(.CNT_W(33)) dut33 (
        .clock         (clock),
        .reset_n       (reset_n),
        .chipselect    (chipselect),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata33),
        .readdatavalid (readdatavalid33)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one bus cycle; returns #1 after the edge ending it
    task automatic step(input logic cs, input logic rd, input logic wr,
                        input logic [2:0] addr, input logic [31:0] wd);
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [31:0] wd);
        step(1'b1, 1'b0, 1'b1, addr, wd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
        step(1'b1, 1'b1, 1'b0, addr, 32'd0);
        chk({name, "_valid"}, {31'd0, readdatavalid}, 32'd1);
        chk(name, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_valid", {31'd0, readdatavalid}, 32'd0);
        reset_n = 1'b1;
        idle();
        chk("idle_valid", {31'd0, readdatavalid}, 32'd0);

        // register map after reset, plus reserved-word writes
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 32'h00000001});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 32'd1409232964});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd4, 32'd0, 1'b1, 32'h00000000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd5, 32'd0, 1'b1, 32'h00000001});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd6, 32'd0, 1'b1, 32'h00000000});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd6, 32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd7, 32'hA5A5A5A5, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd6, 32'd0, 1'b1, 32'h00000000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd7, 32'd0, 1'b1, 32'h00000000});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd1, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 32'd1409232964});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_valid", i), {31'd0, readdatavalid}, {31'd0, vecs[i].exp_v});
            if (vecs[i].exp_v) chk($sformatf("vec%0d_data", i), readdata, vecs[i].exp_d);
        end

        // counter load across the 32-bit carry and consistent LO/HI pair
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd2, 32'hFFFFFFFE);
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd5, 32'd1);
        idle(); idle(); idle();
        rd_chk("carry_lo", 3'd2, 32'd1);
        chk("carry_lo33", readdata33, 32'd1);
        rd_chk("carry_hi", 3'd3, 32'd1);
        chk("carry_hi33", readdata33, 32'd1);
        repeat (10) idle();
        rd_chk("hi_stable", 3'd3, 32'd1);

        // load ignored while running; clear pulse
        wr_reg(3'd2, 32'd5);
        rd_chk("load_ignored_lo", 3'd2, 32'h0000000F);
        wr_reg(3'd5, 32'd3);
        rd_chk("clr_lo", 3'd2, 32'd0);
        rd_chk("clr_hi", 3'd3, 32'd0);
        rd_chk("ctrl_after_clr", 3'd5, 32'd1);
        rd_chk("clr_lo_run", 3'd2, 32'd3);

        // scratch, read-only ID, reset mid-read
        wr_reg(3'd4, 32'hDEADBEEF);
        wr_reg(3'd0, 32'd0);
        rd_chk("scratch_rw", 3'd4, 32'hDEADBEEF);
        rd_chk("id_ro", 3'd0, 32'h00000001);
        wr_reg(3'd5, 32'd0);
        reset_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 3'd4, 32'd0);
        chk("rst_mid_read_valid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_mid_read_data", readdata, 32'd0);
        reset_n = 1'b1;
        rd_chk("rst_scratch", 3'd4, 32'd0);
        rd_chk("rst_ctrl", 3'd5, 32'd1);

        // wrap at 2^CNT_W-1 for both widths
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd2, 32'hFFFFFFFF);
        wr_reg(3'd3, 32'hFFFFFFFF);
        rd_chk("max_lo", 3'd2, 32'hFFFFFFFF);
        chk("max_lo33", readdata33, 32'hFFFFFFFF);
        rd_chk("max_hi", 3'd3, 32'hFFFFFFFF);
        chk("max_hi33", readdata33, 32'h00000001);
        chk("max_hi33_valid", {31'd0, readdatavalid33}, 32'd1);
        wr_reg(3'd5, 32'd1);
        rd_chk("wrap_pre_lo", 3'd2, 32'hFFFFFFFF);
        chk("wrap_pre_lo33", readdata33, 32'hFFFFFFFF);
        rd_chk("wrap_lo", 3'd2, 32'd0);
        chk("wrap_lo33", readdata33, 32'd0);
        rd_chk("wrap_hi", 3'd3, 32'd0);
        chk("wrap_hi33", readdata33, 32'd0);

        // chipselect low ignores everything; concurrent read/write
        step(1'b0, 1'b1, 1'b1, 3'd4, 32'h55555555);
        chk("nocs_valid", {31'd0, readdatavalid}, 32'd0);
        rd_chk("nocs_scratch", 3'd4, 32'd0);
        wr_reg(3'd4, 32'd7);
        step(1'b1, 1'b1, 1'b1, 3'd4, 32'd9);
        chk("rw_valid", {31'd0, readdatavalid}, 32'd1);
        chk("rw_old", readdata, 32'd7);
        rd_chk("rw_new", 3'd4, 32'd9);
        idle();
        chk("end_valid", {31'd0, readdatavalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_system_sysinfo.md
Name: nios_system_sysinfo

Overview:
- Parametrised successor to the fixed two-word system ID slave.
- Avalon-MM slave on the Nios II data master, responding over an 8-word register map with one-cycle registered read latency.
- Returns a build ID and a build timestamp.
- Also provides:
  - a free-running cycle counter (uptime) with an atomic 64-bit read,
  - a software scratch register,
  - a control register.
- Firmware uses it to check image/hardware match and for coarse timing.

Parameters:
- SYSID, 32'h00000001: value returned at word 0.
- TIMESTAMP, 32'd1409232964: build time returned at word 1.
- CNT_W, 64: uptime counter width. Legal range 33..64. Bits above CNT_W-1 read 0.
- SCRATCH_RST, 32'h00000000: reset value of SCRATCH.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- chipselect  in  1  slave select.
- address  in  3  word address.
- read  in  1  read strobe. Accepted when chipselect&read.
- write  in  1  write strobe. Accepted when chipselect&write.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, one clock after an accepted read.

Behaviour:
- Reset (reset_n low at a clock edge):
  - readdata=0, readdatavalid=0.
  - counter=0, hi_snap=0.
  - SCRATCH=SCRATCH_RST.
  - CTRL.en=1.
  - A reset asserted mid-read drops the pending readdatavalid.
- Register map:
  - 0 ID: RO, returns SYSID.
  - 1 TIMESTAMP: RO, returns TIMESTAMP.
  - 2 UPTIME_LO: returns counter[31:0]. The same accepted read latches counter[CNT_W-1:32] into hi_snap.
  - 3 UPTIME_HI: returns hi_snap, zero-extended. It does not sample the live counter.
  - 4 SCRATCH: RW, all 32 bits.
  - 5 CTRL: bit0 en (RW); bit1 clr (write-1 pulse, always reads 0); bits 31:2 read 0.
  - 6-7: reserved. Reads return 0; writes are ignored.
- Read timing:
  - A read accepted in cycle N samples all values as they stand in cycle N, before any update in cycle N.
  - readdata and readdatavalid are asserted in cycle N+1.
  - Back-to-back reads give back-to-back valids.
  - readdata holds its last value when no read is accepted. Bench checks it only under readdatavalid.
- Write timing:
  - Writes take effect at the edge ending the accept cycle.
  - Writes to 0, 1, 6, 7 are ignored.
  - No waitrequest; every access completes.
- Counter:
  - Increments by 1 each cycle when CTRL.en=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - A write with CTRL.clr=1 zeroes the counter and hi_snap at that edge. Clear takes priority over increment.
  - The en bit in the same write is applied normally.
- Counter load (test/debug support):
  - When CTRL.en=0 (value before the write), writes to 2 load counter[31:0] and writes to 3 load counter[CNT_W-1:32].
  - When en=1, these writes are ignored.
- Simultaneous read and write in the same cycle:
  - The write is performed.
  - The read returns the pre-write value and still produces readdatavalid.
  - A read of 2 with a concurrent clr latches the pre-clear upper bits.
- chipselect=0: read and write are ignored entirely, with no hi_snap update.

Test Plan:
- Reset, then read 0, 1, 4, 5, 6 -> readdatavalid exactly one cycle after each read. Data: 1, 1409232964, 0, 1, 0. readdatavalid is 0 before the first read.
- Write CTRL=0, write addr2=32'hFFFFFFFE, write addr3=0, write CTRL=1. Idle 3 cycles, then read 2 then 3 -> LO=1, HI=1: the carry crossed and the pair is consistent. Then read 3 alone 10 cycles later -> still 1.
- With CTRL.en=1, write addr2=5 -> ignored. Write CTRL=3 -> counter reads small (under 10 cycles) on next LO read, CTRL reads 1.
- Write SCRATCH=32'hDEADBEEF, write ID=0 -> SCRATCH reads DEADBEEF, ID still reads 1. Assert reset_n=0 for one cycle -> SCRATCH=0, CTRL=1, and a read issued the cycle before reset yields no readdatavalid.
- CNT_W=33 build: load counter=2^33-1 with en=0, then set en=1 -> after one cycle LO=0 and HI=0 (wrap); HI bits 31:1 always 0.
- chipselect=0 with read=1, write=1 to SCRATCH -> no readdatavalid, SCRATCH unchanged. Concurrent read and write of SCRATCH (old 7, new 9) -> returns 7, a subsequent read returns 9.
